// File: rtl/lfsr_descrambler_gen3.sv
// Gen3 128b/130b receive descrambler: 23-bit Galois LFSR that advances 32 bit-times per beat,
// classifies each 4-beat block from its sync header and first symbol, and bypasses ordered sets.
// Optional build macro DESCR_ERR_CNT_EN adds a saturating err_count[7:0] output.
module lfsr_descrambler_gen3 (
  input  logic        pclk,
  input  logic        reset,
  input  logic [22:0] seed_value,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_block_start,
  input  logic [1:0]  rx_sync_header,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        block_start_out,
  output logic [1:0]  sync_header_out,
  output logic        sync_err,
  output logic        align_err
`ifdef DESCR_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned LFSR_W = 23;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEAT_W = 2;
  // Feedback taps for x^23+x^21+x^16+x^8+x^5+x^2+1 (x^0 term lands in bit 0)
  localparam logic [LFSR_W-1:0] TAPS = 23'h210125;

  typedef enum logic [2:0] {
    CLS_DATA,
    CLS_SKP,
    CLS_EIEOS,
    CLS_OTHER,
    CLS_BAD
  } cls_t;

  // Produce 32 key bits (first serial bit in bit 0) and the LFSR state 32 steps later
  function automatic logic [LFSR_W+DATA_W-1:0] scramble32(input logic [LFSR_W-1:0] s_in);
    logic [LFSR_W-1:0] s;
    logic [DATA_W-1:0] k;
    s = s_in;
    k = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      k[i] = s[LFSR_W-1];
      s    = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? TAPS : '0);
    end
    return {s, k};
  endfunction

  // Block class from sync header and symbol 0 of the first beat
  function automatic cls_t classify(input logic [1:0] hdr, input logic [7:0] sym0);
    cls_t c;
    case (hdr)
      2'b10:   c = CLS_DATA;
      2'b01:   c = (sym0 == 8'hAA) ? CLS_SKP : ((sym0 == 8'h00) ? CLS_EIEOS : CLS_OTHER);
      default: c = CLS_BAD;
    endcase
    return c;
  endfunction

  logic [LFSR_W-1:0] lfsr_q, lfsr_n, lfsr_adv;
  logic [DATA_W-1:0] key, mask;
  logic [BEAT_W-1:0] beat_q, beat_n, beat_cur;
  cls_t              cls_q, cls_n, cls_cur;
  logic [1:0]        hdr_q, hdr_n, hdr_cur;
  logic              synced_q, synced_n;
  logic              take;

  logic [DATA_W-1:0] data_out_n;
  logic              data_valid_n;
  logic              block_start_n;
  logic [1:0]        sync_header_n;
  logic              sync_err_n;
  logic              align_err_n;

  // Next-state and registered-output computation for one beat
  always_comb begin
    {lfsr_adv, key} = scramble32(lfsr_q);
    take     = rx_valid && (synced_q || rx_block_start);
    beat_cur = rx_block_start ? '0 : beat_q;
    cls_cur  = rx_block_start ? classify(rx_sync_header, rx_data[7:0]) : cls_q;
    hdr_cur  = rx_block_start ? rx_sync_header : hdr_q;

    case (cls_cur)
      CLS_DATA:  mask = key;
      CLS_OTHER: mask = (beat_cur == '0) ? {key[DATA_W-1:8], 8'h00} : key;
      default:   mask = '0;
    endcase

    lfsr_n        = lfsr_q;
    beat_n        = beat_q;
    cls_n         = cls_q;
    hdr_n         = hdr_q;
    synced_n      = synced_q;
    data_out_n    = data_out;
    data_valid_n  = 1'b0;
    block_start_n = 1'b0;
    sync_header_n = sync_header_out;
    sync_err_n    = 1'b0;
    align_err_n   = 1'b0;

    if (take) begin
      if (cls_cur == CLS_SKP)
        lfsr_n = lfsr_q;
      else if (cls_cur == CLS_EIEOS && beat_cur == BEAT_W'(3))
        lfsr_n = seed_value;
      else
        lfsr_n = lfsr_adv;
      beat_n        = beat_cur + BEAT_W'(1);
      cls_n         = cls_cur;
      hdr_n         = hdr_cur;
      synced_n      = 1'b1;
      data_out_n    = rx_data ^ mask;
      data_valid_n  = 1'b1;
      block_start_n = rx_block_start;
      sync_header_n = hdr_cur;
      sync_err_n    = rx_block_start && (cls_cur == CLS_BAD);
      align_err_n   = rx_block_start && (beat_q != '0);
    end
  end

  // State and output registers
  always_ff @(posedge pclk) begin
    if (reset) begin
      lfsr_q          <= seed_value;
      beat_q          <= '0;
      cls_q           <= CLS_DATA;
      hdr_q           <= '0;
      synced_q        <= 1'b0;
      data_out        <= '0;
      data_valid      <= 1'b0;
      block_start_out <= 1'b0;
      sync_header_out <= '0;
      sync_err        <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      lfsr_q          <= lfsr_n;
      beat_q          <= beat_n;
      cls_q           <= cls_n;
      hdr_q           <= hdr_n;
      synced_q        <= synced_n;
      data_out        <= data_out_n;
      data_valid      <= data_valid_n;
      block_start_out <= block_start_n;
      sync_header_out <= sync_header_n;
      sync_err        <= sync_err_n;
      align_err       <= align_err_n;
    end
  end

`ifdef DESCR_ERR_CNT_EN
  logic [8:0] err_sum;
  logic [7:0] err_count_n;

  // Saturating sum of this beat's error pulses
  always_comb begin
    err_sum     = 9'(err_count) + 9'(sync_err_n) + 9'(align_err_n);
    err_count_n = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  // Error counter register
  always_ff @(posedge pclk) begin
    if (reset) err_count <= '0;
    else       err_count <= err_count_n;
  end
`endif

endmodule

// File: tb/tb_lfsr_descrambler_gen3.sv
// Scoreboard bench for lfsr_descrambler_gen3: block-level reference model, per-cycle expectation queue.
module tb_lfsr_descrambler_gen3;

  logic        pclk = 1'b0;
  logic        reset;
  logic [22:0] seed_value;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_block_start;
  logic [1:0]  rx_sync_header;
  logic [31:0] data_out;
  logic        data_valid;
  logic        block_start_out;
  logic [1:0]  sync_header_out;
  logic        sync_err;
  logic        align_err;
`ifdef DESCR_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  always #5 pclk = ~pclk;

  lfsr_descrambler_gen3 dut (
    .pclk(pclk), .reset(reset), .seed_value(seed_value), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_block_start(rx_block_start), .rx_sync_header(rx_sync_header),
    .data_out(data_out), .data_valid(data_valid), .block_start_out(block_start_out),
    .sync_header_out(sync_header_out), .sync_err(sync_err), .align_err(align_err)
`ifdef DESCR_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  typedef struct {
    logic        full;
    logic        valid;
    logic [31:0] data;
    logic        bs;
    logic [1:0]  hdr;
    logic        serr;
    logic        aerr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam int C_DATA = 0, C_SKP = 1, C_EIE = 2, C_OTH = 3, C_BAD = 4;
  localparam logic [23:0] POLY = 24'hA10125;

  // reference model state
  logic [22:0] m_lfsr;
  int          m_pos;
  int          m_cls;
  logic        m_synced;
  logic [1:0]  m_hdr;
  logic [7:0]  m_cnt;

  // Key stream: state is a polynomial, each bit-time multiplies by x modulo p(x); output is the x^22 coefficient
  function automatic logic [31:0] take_key();
    logic [31:0] k;
    logic [23:0] t;
    for (int i = 0; i < 32; i++) begin
      k[i] = m_lfsr[22];
      t = {m_lfsr, 1'b0};
      if (t[23]) t = t ^ POLY;
      m_lfsr = t[22:0];
    end
    return k;
  endfunction

  function automatic int classify(input logic [1:0] hdr, input logic [7:0] s0);
    if (hdr == 2'b10) return C_DATA;
    if (hdr == 2'b01) return (s0 == 8'hAA) ? C_SKP : ((s0 == 8'h00) ? C_EIE : C_OTH);
    return C_BAD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock, compared on the falling edge
  always @(negedge pclk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("data_valid", 32'(data_valid), 32'(e.valid));
      check("sync_err", 32'(sync_err), 32'(e.serr));
      check("align_err", 32'(align_err), 32'(e.aerr));
      if (e.valid || e.full) begin
        check("data_out", data_out, e.data);
        check("block_start_out", 32'(block_start_out), 32'(e.bs));
        check("sync_header_out", 32'(sync_header_out), 32'(e.hdr));
      end
`ifdef DESCR_ERR_CNT_EN
      check("err_count", 32'(err_count), 32'(e.cnt));
`endif
    end
  end

  task automatic drive(input logic rst, input logic v, input logic bs, input logic [1:0] hdr,
                       input logic [31:0] d, input exp_t e);
    reset          = rst;
    rx_valid       = v;
    rx_block_start = bs;
    rx_sync_header = hdr;
    rx_data        = d;
    @(posedge pclk);
    q.push_back(e);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '{full: 1'b1, valid: 1'b0, data: '0, bs: 1'b0, hdr: 2'b00, serr: 1'b0, aerr: 1'b0, cnt: 8'h00};
    m_lfsr = seed_value; m_pos = 0; m_cls = C_DATA; m_synced = 1'b0; m_hdr = 2'b00; m_cnt = 8'h00;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 2'b10, $urandom, e);
  endtask

  task automatic idle();
    exp_t e;
    e = '{full: 1'b0, valid: 1'b0, data: '0, bs: 1'b0, hdr: 2'b00, serr: 1'b0, aerr: 1'b0, cnt: m_cnt};
    drive(1'b0, 1'b0, 1'b0, 2'b00, $urandom, e);
  endtask

  task automatic send_beat(input logic bs, input logic [1:0] hdr, input logic [31:0] d);
    exp_t e;
    logic [31:0] k;
    int s;
    e = '{full: 1'b0, valid: 1'b0, data: '0, bs: 1'b0, hdr: 2'b00, serr: 1'b0, aerr: 1'b0, cnt: m_cnt};
    if (!m_synced && !bs) begin
      drive(1'b0, 1'b1, bs, hdr, d, e);
      return;
    end
    if (bs) begin
      e.aerr = (m_pos != 0);
      m_cls  = classify(hdr, d[7:0]);
      m_hdr  = hdr;
      m_pos  = 0;
      e.serr = (m_cls == C_BAD);
    end
    m_synced = 1'b1;
    k = (m_cls == C_SKP) ? 32'h0 : take_key();
    case (m_cls)
      C_DATA:  e.data = d ^ k;
      C_OTH:   e.data = (m_pos == 0) ? {d[31:8] ^ k[31:8], d[7:0]} : d ^ k;
      default: e.data = d;
    endcase
    if (m_cls == C_EIE && m_pos == 3) m_lfsr = seed_value;
    m_pos   = (m_pos + 1) % 4;
    e.valid = 1'b1;
    e.bs    = bs;
    e.hdr   = m_hdr;
    s = int'(m_cnt) + int'(e.serr) + int'(e.aerr);
    m_cnt   = (s > 255) ? 8'hFF : 8'(s);
    e.cnt   = m_cnt;
    drive(1'b0, 1'b1, bs, hdr, d, e);
  endtask

  // pat: 0 zero payload, 1 EIEOS 00/FF pattern, 2 random
  task automatic send_block(input logic [1:0] hdr, input logic [7:0] sym0, input int nbeats,
                            input int stall, input int pat);
    logic [31:0] d;
    for (int i = 0; i < nbeats; i++) begin
      if (stall != 0 && i > 0) idle();
      d = (pat == 0) ? 32'h0 : ((pat == 1) ? 32'hFF00FF00 : 32'($urandom));
      if (i == 0) d[7:0] = sym0;
      send_beat(i == 0, hdr, d);
    end
  endtask

  initial begin
    int r;
    seed_value = 23'h1DBFBC;
    do_reset(3);
    // beats before the first block start are dropped
    send_beat(1'b0, 2'b10, 32'h12345678);
    send_beat(1'b0, 2'b10, 32'h9ABCDEF0);
    // zero-payload DATA: output is the key stream
    for (int b = 0; b < 8; b++) send_block(2'b10, 8'h00, 4, 0, 0);
    // key continues across SKP
    send_block(2'b10, 8'h00, 4, 0, 2);
    send_block(2'b01, 8'hAA, 4, 0, 2);
    send_block(2'b10, 8'h00, 4, 0, 0);
    // EIEOS reload, then DATA from seed
    send_block(2'b01, 8'h00, 4, 0, 1);
    send_block(2'b10, 8'h00, 4, 0, 0);
    // block start at beat 2, then EIEOS completes
    send_block(2'b10, 8'h00, 2, 0, 2);
    send_block(2'b10, 8'h00, 4, 0, 2);
    seed_value = 23'h0F1E2D;
    send_block(2'b01, 8'h00, 4, 0, 1);
    send_block(2'b10, 8'h00, 4, 0, 0);
    // EIEOS cut short does not reload
    send_block(2'b01, 8'h00, 2, 0, 1);
    send_block(2'b10, 8'h00, 4, 0, 0);
    // bad headers and other ordered sets
    send_block(2'b11, 8'h55, 4, 0, 2);
    send_block(2'b00, 8'hAA, 4, 0, 2);
    send_block(2'b01, 8'h1E, 4, 0, 2);
    // stalled DATA block
    send_block(2'b10, 8'h00, 4, 1, 0);
    send_block(2'b10, 8'h00, 4, 1, 2);
    // reset mid-block, then dropped beats until a block start
    send_block(2'b10, 8'h00, 2, 0, 2);
    seed_value = 23'h1DBFBC;
    do_reset(2);
    send_beat(1'b0, 2'b10, 32'hDEADBEEF);
    idle();
    send_block(2'b10, 8'h00, 4, 0, 0);
    // randomized blocks
    for (int b = 0; b < 60; b++) begin
      r = $urandom_range(0, 11);
      if ($urandom_range(0, 7) == 0) seed_value = 23'($urandom);
      case (r)
        0, 1, 2, 3: send_block(2'b10, 8'($urandom), 4, $urandom_range(0, 1), 2);
        4:          send_block(2'b01, 8'hAA, 4, 0, 2);
        5:          send_block(2'b01, 8'h00, 4, $urandom_range(0, 1), 1);
        6:          send_block(2'b01, 8'h2D, 4, 0, 2);
        7:          send_block(2'b11, 8'($urandom), 4, 0, 2);
        8:          send_block(2'b00, 8'($urandom), 4, 0, 2);
        9:          send_block(2'b01, 8'h00, $urandom_range(1, 3), 0, 1);
        default:    send_block(2'b10, 8'($urandom), $urandom_range(1, 3), 0, 2);
      endcase
    end
    idle();
    idle();
    @(negedge pclk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_descrambler_gen3.md
LFSR_DESCRAMBLER_GEN3 -- requirements
Module: lfsr_descrambler_gen3

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 pclk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 seed_value  input  23  per-lane LFSR seed; sampled at reset and at each EIEOS reload.
REQ-005 rx_valid  input  1  rx_data/rx_block_start/rx_sync_header qualified this cycle.
REQ-006 rx_data  input  32  received 4 symbols, symbol 0 in [7:0].
REQ-007 rx_block_start  input  1  first beat of a 130b block.
REQ-008 rx_sync_header  input  2  block sync header; valid when rx_block_start=1.
REQ-009 data_out  output  32  descrambled beat.
REQ-010 data_valid  output  1  data_out/block_start_out/sync_header_out qualified.
REQ-011 block_start_out  output  1  registered copy of rx_block_start.
REQ-012 sync_header_out  output  2  registered header of the current block.
REQ-013 sync_err  output  1  one-cycle pulse: header 2'b00/2'b11 at block start.
REQ-014 align_err  output  1  one-cycle pulse: rx_block_start on beat counter != 0.

Function
REQ-015 LFSR: 23 bits, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, advances 32 bit-times per consumed beat; key bit 0 = lfsr[22], key bits and next state identical to the Gen3 TX 32-bit scrambler equations.
REQ-016 Beat counter 0..3 advances only on rx_valid=1 and wraps 3->0; rx_valid=0 freezes the counter and the LFSR and drives data_valid=0.
REQ-017 rx_block_start=1 forces the beat to counter 0; when the counter was not 0, align_err pulses and the new block is processed normally.
REQ-018 Block class latched at beat 0: DATA (header 10), SKP (header 01, symbol0=8'hAA), EIEOS (header 01, symbol0=8'h00), OTHER_OS (header 01, other symbol0), BAD (header 00/11).
REQ-019 DATA: data_out = rx_data ^ key on all 4 beats; LFSR advances.
REQ-020 SKP: data_out = rx_data unmodified; LFSR does not advance for the whole block.
REQ-021 EIEOS: data_out = rx_data unmodified; after beat 3 is consumed, LFSR loads seed_value.
REQ-022 OTHER_OS: symbol 0 of beat 0 is bypassed, all other symbols are XORed with the key; LFSR advances.
REQ-023 BAD: sync_err pulses; data_out = rx_data unmodified; LFSR advances.
REQ-024 Latency: exactly 1 pclk from a consumed input beat to data_valid=1 with its result; throughput 1 beat per cycle.
REQ-025 An EIEOS block cut short by rx_block_start SHALL NOT reload the LFSR.

Reset
REQ-026 Reset: LFSR=seed_value, beat counter=0, class=DATA, and data_out, data_valid, block_start_out, sync_header_out, sync_err, align_err=0.
REQ-027 Reset asserted mid-block discards the partial block; the first beat after release is processed only when rx_block_start=1, and earlier beats are dropped with data_valid=0.

Configuration
REQ-028 Macro DESCR_ERR_CNT_EN defined: add output err_count[7:0], a saturating count (at 8'hFF) of sync_err plus align_err pulses, cleared by reset; simultaneous pulses add 2.
REQ-029 Macro DESCR_ERR_CNT_EN undefined: no err_count port and no counter logic; all other behaviour is unchanged.

Verification
REQ-030 Seed 23'h1DBFBC, 8 DATA blocks of all-zero payload: data_out equals the TX scrambler key stream bit-exact, 1-cycle latency.
REQ-031 DATA, then SKP (symbol0 8'hAA), then DATA: the second DATA block's key continues exactly where the first ended.
REQ-032 EIEOS block (all 8'h00/8'hFF pattern), then DATA with zero payload: the DATA output equals the key generated from seed_value.
REQ-033 rx_block_start at beat 2: align_err pulses once, the counter restarts, and a later EIEOS completes and reloads.
REQ-034 Header 2'b11: sync_err pulses, data passes unmodified, and err_count increments when DESCR_ERR_CNT_EN is defined.
REQ-035 rx_valid toggled 1/0 every cycle during a DATA block: output stream equals the unstalled run, and data_valid=0 on the idle cycles.
